// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs (ALU, LB, SB) drained one entry per
// cycle onto a registered common data bus with round-robin priority.
// Optional build macro CDB_STATS_EN adds grant/stall statistics counters.
module cdb_arbiter #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear_all,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [31:0]      alu_value,
  input  logic [31:0]      alu_jalr_pc,
  output logic             alu_ready,
  input  logic             lb_valid,
  input  logic [TAG_W-1:0] lb_tag,
  input  logic [31:0]      lb_value,
  output logic             lb_ready,
  input  logic             sb_valid,
  input  logic [TAG_W-1:0] sb_tag,
  output logic             sb_ready,
  output logic             cdb_valid,
  output logic [1:0]       cdb_src,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_value,
  output logic [31:0]      cdb_jalr_pc
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]      stat_grant_alu,
  output logic [31:0]      stat_grant_lb,
  output logic [31:0]      stat_grant_sb,
  output logic [31:0]      stat_stall
`endif
);

  localparam int unsigned NSRC  = 3;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q [NSRC];
  logic [PTR_W-1:0] head_d [NSRC];
  logic [PTR_W-1:0] tail_q [NSRC];
  logic [PTR_W-1:0] tail_d [NSRC];
  logic [CNT_W-1:0] cnt_q  [NSRC];
  logic [CNT_W-1:0] cnt_d  [NSRC];
  logic [TAG_W-1:0] tag_q  [NSRC][DEPTH];
  logic [TAG_W-1:0] tag_d  [NSRC][DEPTH];
  logic [31:0]      val_q  [2][DEPTH];
  logic [31:0]      val_d  [2][DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [1:0]       rr_q, rr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [1:0]       cdb_src_q, cdb_src_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_value_q, cdb_value_d;
  logic [31:0]      cdb_jalr_pc_q, cdb_jalr_pc_d;

  logic [NSRC-1:0]  src_vld, src_rdy, push, pop;
  logic [TAG_W-1:0] src_tag [NSRC];
  logic             gnt_vld;
  logic [1:0]       gnt, cand;

  // (a + b) mod 3 for round-robin pointer arithmetic
  function automatic logic [1:0] rr_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    rr_add = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Source-side handshake: ready depends only on registered occupancy
  always_comb begin
    src_vld    = {sb_valid, lb_valid, alu_valid};
    src_tag[0] = alu_tag;
    src_tag[1] = lb_tag;
    src_tag[2] = sb_tag;
    for (int i = 0; i < NSRC; i++) begin
      src_rdy[i] = rst_n_in && rdy_in && (cnt_q[i] < CNT_W'(DEPTH));
    end
    push = src_vld & src_rdy & {NSRC{~clear_all}};
  end

  assign alu_ready = src_rdy[0];
  assign lb_ready  = src_rdy[1];
  assign sb_ready  = src_rdy[2];

  // Round-robin scan starting at rr over non-empty FIFOs
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      cand = rr_add(rr_q, 2'(k));
      if (!gnt_vld && (cnt_q[cand] != '0)) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
    pop = '0;
    if (gnt_vld && rdy_in && !clear_all) pop[gnt] = 1'b1;
  end

  // FIFO, arbiter pointer and CDB next-state; pause holds, flush clears
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    val_d         = val_q;
    pc_d          = pc_q;
    rr_d          = rr_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_src_d     = cdb_src_q;
    cdb_tag_d     = cdb_tag_q;
    cdb_value_d   = cdb_value_q;
    cdb_jalr_pc_d = cdb_jalr_pc_q;
    if (rdy_in) begin
      if (clear_all) begin
        for (int i = 0; i < NSRC; i++) begin
          head_d[i] = '0;
          tail_d[i] = '0;
          cnt_d[i]  = '0;
        end
        rr_d        = 2'd0;
        cdb_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (push[i]) begin
            tag_d[i][tail_q[i]] = src_tag[i];
            tail_d[i]           = PTR_W'(tail_q[i] + 1'b1);
          end
          if (pop[i]) head_d[i] = PTR_W'(head_q[i] + 1'b1);
          case ({push[i], pop[i]})
            2'b10:   cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
            2'b01:   cnt_d[i] = CNT_W'(cnt_q[i] - 1'b1);
            default: cnt_d[i] = cnt_q[i];
          endcase
        end
        if (push[0]) begin
          val_d[0][tail_q[0]] = alu_value;
          pc_d[tail_q[0]]     = alu_jalr_pc;
        end
        if (push[1]) val_d[1][tail_q[1]] = lb_value;
        cdb_valid_d = gnt_vld;
        if (gnt_vld) begin
          cdb_src_d     = gnt;
          cdb_tag_d     = tag_q[gnt][head_q[gnt]];
          cdb_value_d   = (gnt == 2'd2) ? 32'd0 : val_q[gnt[0]][head_q[gnt]];
          cdb_jalr_pc_d = (gnt == 2'd0) ? pc_q[head_q[0]] : 32'd0;
          rr_d          = rr_add(gnt, 2'd1);
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NSRC; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) tag_q[i][j] <= '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        val_q[0][j] <= '0;
        val_q[1][j] <= '0;
        pc_q[j]     <= '0;
      end
      rr_q          <= 2'd0;
      cdb_valid_q   <= 1'b0;
      cdb_src_q     <= 2'd0;
      cdb_tag_q     <= '0;
      cdb_value_q   <= '0;
      cdb_jalr_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      tag_q         <= tag_d;
      val_q         <= val_d;
      pc_q          <= pc_d;
      rr_q          <= rr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_src_q     <= cdb_src_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_jalr_pc_q <= cdb_jalr_pc_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_src     = cdb_src_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_jalr_pc = cdb_jalr_pc_q;

`ifdef CDB_STATS_EN
  logic [31:0] st_alu_q, st_alu_d, st_lb_q, st_lb_d, st_sb_q, st_sb_d, st_stall_q, st_stall_d;

  // Statistics next-state: grants and backpressured cycles, frozen on pause
  always_comb begin
    st_alu_d   = st_alu_q;
    st_lb_d    = st_lb_q;
    st_sb_d    = st_sb_q;
    st_stall_d = st_stall_q;
    if (rdy_in) begin
      st_alu_d = st_alu_q + 32'(pop[0]);
      st_lb_d  = st_lb_q + 32'(pop[1]);
      st_sb_d  = st_sb_q + 32'(pop[2]);
      st_stall_d = st_stall_q + 32'(|(src_vld & ~src_rdy));
    end
  end

  // Statistics registers, cleared by reset only
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_alu_q   <= '0;
      st_lb_q    <= '0;
      st_sb_q    <= '0;
      st_stall_q <= '0;
    end else begin
      st_alu_q   <= st_alu_d;
      st_lb_q    <= st_lb_d;
      st_sb_q    <= st_sb_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_grant_alu = st_alu_q;
  assign stat_grant_lb  = st_lb_q;
  assign stat_grant_sb  = st_sb_q;
  assign stat_stall     = st_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default parameters).
module tb_cdb_arbiter;
  localparam int unsigned TAG_W = 4;

  logic             clk_in, rst_n_in, rdy_in, clear_all;
  logic             alu_valid, lb_valid, sb_valid;
  logic [TAG_W-1:0] alu_tag, lb_tag, sb_tag;
  logic [31:0]      alu_value, alu_jalr_pc, lb_value;
  logic             alu_ready, lb_ready, sb_ready;
  logic             cdb_valid;
  logic [1:0]       cdb_src;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value, cdb_jalr_pc;
`ifdef CDB_STATS_EN
  logic [31:0]      sg_alu, sg_lb, sg_sb, s_stall;
`endif

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.TAG_W(TAG_W), .DEPTH(2)) dut (
`ifdef CDB_STATS_EN
    .stat_grant_alu(sg_alu), .stat_grant_lb(sg_lb),
    .stat_grant_sb(sg_sb), .stat_stall(s_stall),
`endif
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_all(clear_all),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value),
    .alu_jalr_pc(alu_jalr_pc), .alu_ready(alu_ready),
    .lb_valid(lb_valid), .lb_tag(lb_tag), .lb_value(lb_value), .lb_ready(lb_ready),
    .sb_valid(sb_valid), .sb_tag(sb_tag), .sb_ready(sb_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_jalr_pc(cdb_jalr_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear_all = 1'b0;
    alu_valid = 1'b0; lb_valid = 1'b0; sb_valid = 1'b0;
    alu_tag = '0; lb_tag = '0; sb_tag = '0;
    alu_value = '0; alu_jalr_pc = '0; lb_value = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n_in = 1'b0;
    #3;
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc, alu_ready, lb_ready, sb_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b src=%0d tag=%0d val=%h pc=%h rdy=%b%b%b, want all 0",
               cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc, alu_ready, lb_ready, sb_ready);
    end
    do_reset();
    checks++;
    if ({alu_ready, lb_ready, sb_ready, cdb_valid} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b%b%b v=%b, want rdy=111 v=0",
               alu_ready, lb_ready, sb_ready, cdb_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    alu_valid = 1'b1; alu_tag = 4'd5; alu_value = 32'h1234; alu_jalr_pc = 32'h80;
    tick();
    idle();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass: got v=%b, want 0", cdb_valid);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc} !== {1'b1, 2'd0, 4'd5, 32'h1234, 32'h80}) begin
      errors++;
      $display("FAIL single_bcast: got v=%b src=%0d tag=%0d val=%h pc=%h, want 1/0/5/1234/80",
               cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_one_cycle: got v=%b, want 0", cdb_valid);
    end
  endtask

  task automatic test_all_three();
    do_reset();
    alu_valid = 1'b1; alu_tag = 4'd1; alu_value = 32'h11; alu_jalr_pc = 32'h100;
    lb_valid = 1'b1; lb_tag = 4'd2; lb_value = 32'h22;
    sb_valid = 1'b1; sb_tag = 4'd3;
    tick();
    idle();
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc} !== {1'b1, 2'd0, 4'd1, 32'h11, 32'h100}) begin
      errors++; $display("FAIL order_alu: got v=%b src=%0d tag=%0d val=%h pc=%h, want 1/0/1/11/100",
                         cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc} !== {1'b1, 2'd1, 4'd2, 32'h22, 32'h0}) begin
      errors++; $display("FAIL order_lb: got v=%b src=%0d tag=%0d val=%h pc=%h, want 1/1/2/22/0",
                         cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc} !== {1'b1, 2'd2, 4'd3, 32'h0, 32'h0}) begin
      errors++; $display("FAIL order_sb: got v=%b src=%0d tag=%0d val=%h pc=%h, want 1/2/3/0/0",
                         cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL order_drained: got v=%b, want 0", cdb_valid);
    end
    // rr is back at ALU: a simultaneous LB/ALU pair must go ALU first
    alu_valid = 1'b1; alu_tag = 4'd4; lb_valid = 1'b1; lb_tag = 4'd5;
    tick();
    idle();
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd0, 4'd4}) begin
      errors++; $display("FAIL rr_wrap_first: got v=%b src=%0d tag=%0d, want 1/0/4", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd1, 4'd5}) begin
      errors++; $display("FAIL rr_wrap_second: got v=%b src=%0d tag=%0d, want 1/1/5", cdb_valid, cdb_src, cdb_tag);
    end
  endtask

  task automatic test_backpressure();
    int a_n, l_n, k;
    logic ar, lr;
    logic [1:0] e_src;
    logic [TAG_W-1:0] e_tag;
    do_reset();
    a_n = 0; l_n = 0;
    for (int n = 1; n <= 9; n++) begin
      alu_valid = 1'b1; alu_tag = 4'(a_n); alu_value = 32'(a_n);
      lb_valid = (l_n < 4); lb_tag = 4'(8 + l_n); lb_value = 32'(100 + l_n);
      ar = alu_ready; lr = lb_ready;
      tick();
      if (ar) a_n++;
      if (lr && lb_valid) l_n++;
      if (n == 2) begin
        checks++;
        if (lb_ready !== 1'b0) begin
          errors++; $display("FAIL lb_full_ready: got %b, want 0", lb_ready);
        end
      end
      if (n >= 2) begin
        k = n - 2;
        e_src = (k % 2 == 0) ? 2'd0 : 2'd1;
        e_tag = (k % 2 == 0) ? 4'(k / 2) : 4'(8 + k / 2);
        checks++;
        if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, e_src, e_tag}) begin
          errors++; $display("FAIL alternate_n%0d: got v=%b src=%0d tag=%0d, want 1/%0d/%0d",
                             n, cdb_valid, cdb_src, cdb_tag, e_src, e_tag);
        end
      end
    end
    idle();
  endtask

  task automatic test_clear();
    do_reset();
    alu_valid = 1'b1; alu_tag = 4'd1; lb_valid = 1'b1; lb_tag = 4'd2; sb_valid = 1'b1; sb_tag = 4'd3;
    tick();
    tick();
    clear_all = 1'b1; alu_tag = 4'hF; lb_tag = 4'hE; sb_tag = 4'hD;
    tick();
    checks++;
    if ({cdb_valid, alu_ready, lb_ready, sb_ready} !== 4'b0111) begin
      errors++; $display("FAIL clear_state: got v=%b rdy=%b%b%b, want v=0 rdy=111",
                         cdb_valid, alu_ready, lb_ready, sb_ready);
    end
    idle();
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++; $display("FAIL clear_stale_%0d: got v=%b tag=%0d, want v=0", n, cdb_valid, cdb_tag);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    alu_valid = 1'b1; alu_tag = 4'd1; lb_valid = 1'b1; lb_tag = 4'd2; sb_valid = 1'b1; sb_tag = 4'd3;
    tick();
    idle();
    tick();
    rdy_in = 1'b0; alu_valid = 1'b1; alu_tag = 4'd9;
    #1;
    checks++;
    if ({alu_ready, lb_ready, sb_ready} !== 3'b000) begin
      errors++; $display("FAIL pause_ready: got %b%b%b, want 000", alu_ready, lb_ready, sb_ready);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd0, 4'd1}) begin
        errors++; $display("FAIL pause_frozen_%0d: got v=%b src=%0d tag=%0d, want 1/0/1",
                           n, cdb_valid, cdb_src, cdb_tag);
      end
    end
    idle();
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd1, 4'd2}) begin
      errors++; $display("FAIL resume_lb: got v=%b src=%0d tag=%0d, want 1/1/2", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag} !== {1'b1, 2'd2, 4'd3}) begin
      errors++; $display("FAIL resume_sb: got v=%b src=%0d tag=%0d, want 1/2/3", cdb_valid, cdb_src, cdb_tag);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL resume_no_paused_push: got v=%b tag=%0d, want v=0", cdb_valid, cdb_tag);
    end
    alu_valid = 1'b1; alu_tag = 4'd7; alu_value = 32'h77; alu_jalr_pc = 32'h70;
    tick();
    idle();
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value} !== {1'b1, 2'd0, 4'd7, 32'h77}) begin
      errors++; $display("FAIL pre_async_bcast: got v=%b tag=%0d val=%h, want 1/7/77", cdb_valid, cdb_tag, cdb_value);
    end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc, alu_ready, lb_ready, sb_ready} !== '0) begin
      errors++; $display("FAIL async_reset: got v=%b src=%0d tag=%0d val=%h pc=%h rdy=%b%b%b, want all 0",
                         cdb_valid, cdb_src, cdb_tag, cdb_value, cdb_jalr_pc, alu_ready, lb_ready, sb_ready);
    end
    #2 rst_n_in = 1'b1;
    #1;
  endtask

`ifdef CDB_STATS_EN
  task automatic test_stats();
    do_reset();
    alu_valid = 1'b1; lb_valid = 1'b1;
    repeat (3) tick();
    lb_valid = 1'b0;
    repeat (3) tick();
    idle();
    repeat (3) tick();
    alu_valid = 1'b1;
    repeat (6) tick();
    idle();
    repeat (2) tick();
    lb_valid = 1'b1;
    repeat (2) tick();
    idle();
    repeat (2) tick();
    sb_valid = 1'b1;
    tick();
    idle();
    repeat (2) tick();
    clear_all = 1'b1;
    tick();
    idle();
    checks++;
    if ({sg_alu, sg_lb, sg_sb, s_stall} !== {32'd10, 32'd4, 32'd1, 32'd3}) begin
      errors++; $display("FAIL stats: got alu=%0d lb=%0d sb=%0d stall=%0d, want 10/4/1/3",
                         sg_alu, sg_lb, sg_sb, s_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_backpressure();
    test_clear();
    test_pause();
`ifdef CDB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-bus arbiter between the execution units (ALU reservation station, load buffer, store buffer) and the reorder buffer. Each source pushes finished results into its own small FIFO; the block drains one entry per cycle onto a single registered common data bus (CDB) using round-robin priority. This removes same-cycle writeback collisions at the ROB and gives sources explicit backpressure. A `clear_all` from the ROB flushes all pending results.

## Interface
Parameters:
- `TAG_W`, 4, ROB index width (matches `` `ROB_WIDTH_BIT ``)
- `DEPTH`, 2, entries per source FIFO; power of two, ≥2

Ports:
- `clk_in` in 1, single clock
- `rst_n_in` in 1, reset; asynchronous, active-low
- `rdy_in` in 1, global pause when low
- `clear_all` in 1, misprediction flush from ROB
- `alu_valid` in 1; `alu_tag` in TAG_W; `alu_value` in 32; `alu_jalr_pc` in 32; `alu_ready` out 1
- `lb_valid` in 1; `lb_tag` in TAG_W; `lb_value` in 32; `lb_ready` out 1
- `sb_valid` in 1; `sb_tag` in TAG_W; `sb_ready` out 1
- `cdb_valid` out 1, broadcast valid (one cycle per result)
- `cdb_src` out 2, 0=ALU, 1=LB, 2=SB
- `cdb_tag` out TAG_W, destination ROB entry
- `cdb_value` out 32, result (0 for SB)
- `cdb_jalr_pc` out 32, jalr target (0 unless ALU)

## Operation
- Per source: circular FIFO, head/tail pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits; pointers wrap DEPTH-1→0.
- `x_ready` = `rdy_in` && count<DEPTH, from registered count only (no pop-dependent ready). Push on edge when `x_valid && x_ready && !clear_all`. Valid without ready: not captured; source must hold.
- Arbiter: pointer `rr` ∈ {0,1,2}. Each cycle, grant the first non-empty FIFO scanning rr, rr+1, rr+2 (mod 3). On grant g: pop FIFO g, load CDB registers, `rr <= (g+1) mod 3`. No grant: `cdb_valid <= 0`, rr unchanged.
- Fairness: a non-empty FIFO is granted within 3 cycles.
- Simultaneous push and pop on the same FIFO in one edge: both occur, count unchanged.
- `clear_all` high at an edge (with `rdy_in`): all counts/pointers → 0, `rr` → 0, `cdb_valid` → 0, no pushes, no grant. Takes priority over everything.
- `rdy_in` low: no push, no pop, all state and CDB outputs hold; readies low.
- Reset (async, any time including mid-drain): all FIFOs empty, `rr`=0, `cdb_valid`=0, `cdb_src`=0, `cdb_tag`=0, `cdb_value`=0, `cdb_jalr_pc`=0; readies low while `rst_n_in` low, high (DEPTH free) afterward.

## Timing
- Latency: result pushed at edge k appears on CDB in the cycle after edge k+1 (2 edges), if it wins arbitration; no bypass.
- Throughput: 1 result/cycle aggregate; sustained per-source rate 1/cycle only when other FIFOs empty.
- `cdb_valid` high exactly one cycle per popped entry; ROB samples it on the following edge.
- Ready reflects count after previous edge; a full FIFO accepts again one cycle after its pop edge.

## Configuration
- `CDB_STATS_EN` defined: adds outputs `stat_grant_alu`, `stat_grant_lb`, `stat_grant_sb`, `stat_stall` (32 bits each). Grant counters +1 per grant to that source; `stat_stall` +1 per cycle where any `x_valid && !x_ready` with `rdy_in` high. Wrap modulo 2^32, cleared by reset only (not by `clear_all`), held while `rdy_in` low.
- Not defined: these ports and counters are absent; behaviour otherwise identical.

## Test plan
- Single ALU push tag 5, value 0x1234, jalr_pc 0x80 at edge 1 → `cdb_valid`=1, src 0, tag 5, value 0x1234, jalr_pc 0x80 after edge 2, one cycle only.
- ALU, LB, SB all push (tags 1,2,3) same edge after reset → broadcast order ALU, LB, SB on three consecutive cycles; rr=0 afterward.
- Hold `lb_valid` 4 cycles with DEPTH=2 while ALU floods → `lb_ready` drops after 2 pushes; LB granted at least every 3rd cycle (exactly every other cycle with only ALU and LB); all 4 LB tags emerge in order.
- Fill all FIFOs, assert `clear_all` with new pushes that edge → next cycle `cdb_valid`=0, all readies 1, no stale tag ever broadcast.
- Pull `rdy_in` low for 3 cycles mid-drain → CDB outputs frozen, no pushes; resumes with next entry in sequence; assert `rst_n_in` low asynchronously mid-cycle → outputs zero immediately.
- With `CDB_STATS_EN`: 10 ALU, 4 LB, 1 SB results plus 3 backpressured cycles → counters read 10, 4, 1, 3.
